// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - Shared CDB lane layout, packing helper and index-width helper
package cdb_pkg;

    localparam int CDB_TAG_W  = 4;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_LANE_W = 1 + CDB_TAG_W + CDB_DATA_W;

    localparam int DATA_LSB = 0;
    localparam int TAG_LSB  = CDB_DATA_W;
    localparam int DONE_BIT = CDB_DATA_W + CDB_TAG_W;

    function automatic logic [CDB_LANE_W-1:0] cdb_lane(
        input logic                  done,
        input logic [CDB_TAG_W-1:0]  tag,
        input logic [CDB_DATA_W-1:0] data
    );
        return {done, tag, data};
    endfunction

    // Pointer width; a single-entry structure still gets a 1-bit pointer.
    function automatic int cdb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - Per-source result buffer with freeze and flush
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = cdb_idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW-1:0] head_nxt, tail_nxt;

    // Depth 1 keeps both pointers pinned at zero.
    assign head_nxt = (DEPTH == 1) ? '0 : head + 1'b1;
    assign tail_nxt = (DEPTH == 1) ? '0 : tail + 1'b1;
    assign dout     = mem[head];

    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in && push) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail_nxt;
                if (pop)  head <= head_nxt;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
        count <= CW'(DEPTH));
    a_no_empty_pop: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(rdy_in && !flush_in && pop && count == '0));

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - N-source, M-lane common data bus with round-robin multi-grant
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int N_PORTS    = 2,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int BYPASS     = 1
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                rdy_in,
    input  logic                                flush_in,
    input  logic [N_SRC-1:0]                    src_valid,
    input  logic [N_SRC*TAG_W-1:0]              src_tag,
    input  logic [N_SRC*DATA_W-1:0]             src_data,
    output logic [N_SRC-1:0]                    src_ready,
    output logic [N_PORTS*(1+TAG_W+DATA_W)-1:0] cdb_out
);

    localparam int LANE_W = 1 + TAG_W + DATA_W;
    localparam int ENT_W  = TAG_W + DATA_W;
    localparam int SW     = cdb_idx_w(N_SRC);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [SW-1:0]    rr_ptr, rr_nxt, last_src;
    logic             any_grant;
    logic [CW-1:0]    count    [N_SRC];
    logic [ENT_W-1:0] head     [N_SRC];
    logic [ENT_W-1:0] cand_ent [N_SRC];
    logic [N_SRC-1:0] accept, cand, grant, push, pop;

    logic [N_PORTS-1:0][LANE_W-1:0] lane_nxt;
    logic [N_PORTS*LANE_W-1:0]      cdb_q;

    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        logic [ENT_W-1:0] incoming;
        logic             empty;

        assign incoming     = {src_tag[s*TAG_W +: TAG_W], src_data[s*DATA_W +: DATA_W]};
        assign empty        = (count[s] == '0);
        // Readiness looks only at the registered count, never at this cycle's pop.
        assign src_ready[s] = rst_in & rdy_in & ~flush_in & (count[s] < CW'(FIFO_DEPTH));
        assign accept[s]    = src_valid[s] & src_ready[s];
        assign cand[s]      = rdy_in & ~flush_in & (~empty | ((BYPASS != 0) & accept[s]));
        assign cand_ent[s]  = empty ? incoming : head[s];
        assign pop[s]       = grant[s] & ~empty;
        assign push[s]      = accept[s] & ~(grant[s] & empty);

        cdb_src_fifo #(
            .W     (ENT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .rdy_in   (rdy_in),
            .flush_in (flush_in),
            .push     (push[s]),
            .pop      (pop[s]),
            .din      (incoming),
            .dout     (head[s]),
            .count    (count[s])
        );
    end

    // Rotate-scan from rr_ptr; the i-th candidate found fills lane i.
    always_comb begin
        int            n;
        logic [SW-1:0] idx;
        grant     = '0;
        lane_nxt  = '0;
        last_src  = rr_ptr;
        any_grant = 1'b0;
        n         = 0;
        for (int i = 0; i < N_SRC; i++) begin
            idx = SW'((int'(rr_ptr) + i) % N_SRC);
            if (cand[idx] && n < N_PORTS) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < N_PORTS; k++) begin
                    if (k == n) lane_nxt[k] = {1'b1, cand_ent[idx]};
                end
                n         = n + 1;
                last_src  = idx;
                any_grant = 1'b1;
            end
        end
    end

    assign rr_nxt  = (last_src == SW'(N_SRC - 1)) ? '0 : last_src + 1'b1;
    assign cdb_out = cdb_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rr_ptr <= '0;
            cdb_q  <= '0;
        end else if (rdy_in) begin
            cdb_q <= flush_in ? '0 : lane_nxt;
            if (!flush_in && any_grant) rr_ptr <= rr_nxt;
        end
    end

    a_grant_sane: assert property (@(posedge clk_in) disable iff (!rst_in)
        ($countones(grant) <= N_PORTS) && ((grant & ~cand) == '0));

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - Randomized queue-model bench for cdb_arbiter (2-lane and 1-lane instances)
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int LW    = CDB_LANE_W;

    logic         clk_in = 1'b0;
    logic         rst_in, rdy_in, flush_in;
    logic [3:0]   src_valid;
    logic [15:0]  src_tag;
    logic [127:0] src_data;
    logic [3:0]   rdy0, rdy1;
    logic [2*LW-1:0] cdb0;
    logic [LW-1:0]   cdb1;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(.N_SRC(4), .N_PORTS(2), .DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH), .BYPASS(1)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(rdy0), .cdb_out(cdb0)
    );

    cdb_arbiter #(.N_SRC(4), .N_PORTS(1), .DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH), .BYPASS(1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .src_valid(src_valid), .src_tag(src_tag), .src_data(src_data),
        .src_ready(rdy1), .cdb_out(cdb1)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: one queue of {tag,data} per source per instance (index m*4+s).
    logic [35:0]     mq [8][$];
    int              rr_m [2];
    logic [2*LW-1:0] exp_cdb [2];

    function automatic logic [3:0] model_ready(input int m);
        logic [3:0] r;
        for (int s = 0; s < N; s++)
            r[s] = rst_in && rdy_in && !flush_in && (mq[m*4+s].size() < DEPTH);
        return r;
    endfunction

    task automatic model_step(input int m);
        int              p, n, last, s;
        logic [3:0]      acc;
        logic [2*LW-1:0] lanes;
        logic [35:0]     item, inc;
        p = (m == 0) ? 2 : 1;
        if (flush_in) begin
            for (int k = 0; k < N; k++) mq[m*4+k].delete();
            exp_cdb[m] = '0;
            return;
        end
        for (int k = 0; k < N; k++) acc[k] = src_valid[k] && (mq[m*4+k].size() < DEPTH);
        lanes = '0;
        n     = 0;
        last  = -1;
        for (int i = 0; i < N; i++) begin
            s   = (rr_m[m] + i) % N;
            inc = {src_tag[s*4 +: 4], src_data[s*32 +: 32]};
            if (n < p && (mq[m*4+s].size() > 0 || acc[s])) begin
                if (mq[m*4+s].size() > 0) item = mq[m*4+s].pop_front();
                else begin
                    item   = inc;
                    acc[s] = 1'b0;
                end
                lanes[n*LW +: LW] = {1'b1, item};
                n    = n + 1;
                last = s;
            end
        end
        for (int k = 0; k < N; k++)
            if (acc[k]) mq[m*4+k].push_back({src_tag[k*4 +: 4], src_data[k*32 +: 32]});
        if (last >= 0) rr_m[m] = (last + 1) % N;
        exp_cdb[m] = lanes;
    endtask

    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int k = 0; k < 8; k++) mq[k].delete();
            rr_m    = '{0, 0};
            exp_cdb = '{default: '0};
        end else if (rdy_in) begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk_in) begin
        check("dut0_ready", 128'(rdy0), 128'(model_ready(0)));
        check("dut1_ready", 128'(rdy1), 128'(model_ready(1)));
        check("dut0_cdb",   128'(cdb0), 128'(exp_cdb[0]));
        check("dut1_cdb",   128'(cdb1), 128'(exp_cdb[1]));
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in    = 1'b0;
        rdy_in    = 1'b1;
        flush_in  = 1'b0;
        src_valid = 4'hF;
        src_tag   = {4'd11, 4'd10, 4'd9, 4'd8};
        src_data  = {32'h103, 32'h102, 32'h101, 32'h100};

        // Reset holds everything quiet even with all sources offering.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_ready", 128'(rdy0), 128'(4'b0000));
        check("rst_cdb",   128'(cdb0), 128'(0));
        tick();
        rst_in = 1'b1;
        @(negedge clk_in);
        check("post_rst_ready", 128'(rdy0), 128'(4'b1111));

        // All four push together from rr_ptr=0.
        tick();
        src_valid = 4'h0;
        @(negedge clk_in);
        check("all4_first",  128'(cdb0),
              128'({cdb_lane(1'b1, 4'd9, 32'h101), cdb_lane(1'b1, 4'd8, 32'h100)}));
        tick();
        @(negedge clk_in);
        check("all4_second", 128'(cdb0),
              128'({cdb_lane(1'b1, 4'd11, 32'h103), cdb_lane(1'b1, 4'd10, 32'h102)}));
        tick();

        // Single bypassed result from src0.
        src_valid = 4'b0001;
        src_tag   = 16'h0003;
        src_data  = 128'h1234;
        tick();
        src_valid = 4'h0;
        @(negedge clk_in);
        check("bypass_lanes", 128'(cdb0),
              128'({cdb_lane(1'b0, 4'd0, 32'h0), cdb_lane(1'b1, 4'd3, 32'h1234)}));
        repeat (4) tick();

        // src2 streams every cycle into the one-lane instance.
        for (int i = 0; i < 8; i++) begin
            src_valid = 4'b0100;
            src_tag   = 16'(i) << 8;
            src_data  = 128'(32'hA0 + i) << 64;
            @(negedge clk_in);
            check("stream_ready2", 128'(rdy1[2]), 128'(1'b1));
            if (i > 0)
                check("stream_order", 128'(cdb1),
                      128'(cdb_lane(1'b1, 4'(i - 1), 32'hA0 + 32'(i - 1))));
            tick();
        end
        src_valid = 4'h0;
        repeat (2) tick();

        // Fill buffers, then flush.
        src_valid = 4'hF;
        src_tag   = 16'h7654;
        src_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        tick();
        src_valid = 4'b0111;
        tick();
        src_valid = 4'hF;
        flush_in  = 1'b1;
        @(negedge clk_in);
        check("flush_ready_low", 128'(rdy0), 128'(4'b0000));
        tick();
        flush_in  = 1'b0;
        src_valid = 4'h0;
        @(negedge clk_in);
        check("flush_cdb0",  128'(cdb0), 128'(0));
        check("flush_cdb1",  128'(cdb1), 128'(0));
        check("flush_ready", 128'(rdy1), 128'(4'b1111));

        // Freeze while a done lane is on the bus.
        src_valid = 4'b0010;
        src_tag   = 16'h0050;
        src_data  = 128'h55 << 32;
        tick();
        rdy_in    = 1'b0;
        src_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            check("freeze_cdb",   128'(cdb0[LW-1:0]), 128'(cdb_lane(1'b1, 4'd5, 32'h55)));
            check("freeze_ready", 128'(rdy0), 128'(4'b0000));
            tick();
        end
        rdy_in    = 1'b1;
        src_valid = 4'h0;
        repeat (2) tick();

        // Random traffic with freezes, flushes and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            src_valid = 4'($urandom);
            src_tag   = 16'($urandom);
            src_data  = {$urandom, $urandom, $urandom, $urandom};
            rdy_in    = ($urandom_range(0, 9) != 0);
            flush_in  = ($urandom_range(0, 24) == 0);
            if (c == 300) rst_in = 1'b0;
            if (c == 302) rst_in = 1'b1;
            tick();
        end

        @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
